// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: pipeline hazard-control signal bundle; master = pipeline/memory side, slave = controller.
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use/branch hazards and multi-cycle memory sequencing for the 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_hazard_if.slave bus
);
    localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic          timeout_n;
    logic          lw_stall, mem_stall;

    assign bus.ForwardAE = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs1E) ? 2'b10 :
                           (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E) ? 2'b01 : 2'b00;
    assign bus.ForwardBE = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs2E) ? 2'b10 :
                           (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E) ? 2'b01 : 2'b00;

    assign lw_stall  = bus.ResultSrcE && bus.RdE != 5'd0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    assign mem_stall = (state == HALT) ||
                       (state == MEM_WAIT && !bus.mem_ready) ||
                       (state == RUN && bus.MemReqM && !bus.mem_ready);

    // A memory freeze holds EX, so any branch flush waits until the pipeline moves again.
    assign bus.StallF = mem_stall || (lw_stall && !bus.PCSrcE);
    assign bus.StallD = bus.StallF;
    assign bus.StallE = mem_stall;
    assign bus.StallM = mem_stall;
    assign bus.FlushW = mem_stall;
    assign bus.FlushD = !mem_stall && bus.PCSrcE;
    assign bus.FlushE = !mem_stall && (lw_stall || bus.PCSrcE);

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        timeout_n  = bus.mem_timeout;
        case (state)
            RUN: if (bus.MemReqM && !bus.mem_ready) begin
                state_n    = MEM_WAIT;
                wait_cnt_n = WW'(1);
            end
            MEM_WAIT: if (bus.mem_ready) begin
                state_n    = RUN;
                wait_cnt_n = '0;
            end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                state_n   = HALT;
                timeout_n = 1'b1;
            end else begin
                wait_cnt_n = wait_cnt + WW'(1);
            end
            HALT: state_n = HALT;
            default: begin
                state_n    = RUN;
                wait_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            wait_cnt        <= '0;
            bus.mem_timeout <= 1'b0;
        end else begin
            state           <= state_n;
            wait_cnt        <= wait_cnt_n;
            bus.mem_timeout <= timeout_n;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cycles <= '0;
            bus.flush_count  <= '0;
        end else begin
            bus.stall_cycles <= bus.stall_cycles + CNT_W'(bus.StallF);
            bus.flush_count  <= bus.flush_count + CNT_W'(bus.FlushD);
        end
    end
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed controls, MAX_WAIT=4.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    pipe_hazard_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] LWS  = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] MEMS = 7'b1111001;

    function automatic logic [6:0] ctrl();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        {bus.Rs1D, bus.Rs2D, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RdM, bus.RdW} = '0;
        {bus.ResultSrcE, bus.RegWriteM, bus.RegWriteW, bus.PCSrcE, bus.MemReqM, bus.mem_ready} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        clear_inputs();
        tick();
        do_reset();
        check("reset_ctrl", 32'(ctrl()), 32'(IDLE));
        check("reset_timeout", 32'(bus.mem_timeout), 32'd0);
        check("reset_stall_cnt", bus.stall_cycles, 32'd0);
        check("reset_flush_cnt", bus.flush_count, 32'd0);

        bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
        bus.Rs1E = 5'd5; bus.Rs2E = 5'd0;
        settle();
        check("fwd_a_mem", 32'(bus.ForwardAE), 32'd2);
        check("fwd_b_none", 32'(bus.ForwardBE), 32'd0);
        bus.RegWriteM = 1'b0;
        settle();
        check("fwd_a_wb", 32'(bus.ForwardAE), 32'd1);
        bus.RegWriteM = 1'b1; bus.RdM = 5'd0; bus.Rs2E = 5'd5;
        settle();
        check("fwd_a_rdm0", 32'(bus.ForwardAE), 32'd1);
        check("fwd_b_wb", 32'(bus.ForwardBE), 32'd1);
        bus.RdW = 5'd6;
        settle();
        check("fwd_a_nomatch", 32'(bus.ForwardAE), 32'd0);
        clear_inputs();

        bus.ResultSrcE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
        settle();
        check("lw_rs2", 32'(ctrl()), 32'(LWS));
        bus.Rs2D = 5'd0; bus.Rs1D = 5'd7;
        settle();
        check("lw_rs1", 32'(ctrl()), 32'(LWS));
        bus.RdE = 5'd0; bus.Rs1D = 5'd0;
        settle();
        check("lw_rd0", 32'(ctrl()), 32'(IDLE));
        bus.RdE = 5'd7; bus.Rs1D = 5'd7; bus.ResultSrcE = 1'b0;
        settle();
        check("lw_not_load", 32'(ctrl()), 32'(IDLE));
        bus.ResultSrcE = 1'b1; bus.PCSrcE = 1'b1;
        settle();
        check("br_over_lw", 32'(ctrl()), 32'(BR));
        clear_inputs();
        bus.PCSrcE = 1'b1;
        settle();
        check("br_only", 32'(ctrl()), 32'(BR));
        clear_inputs();

        bus.MemReqM = 1'b1;
        settle();
        check("mw_c1", 32'(ctrl()), 32'(MEMS));
        tick();
        check("mw_c2", 32'(ctrl()), 32'(MEMS));
        bus.PCSrcE = 1'b1; bus.ResultSrcE = 1'b1; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
        settle();
        check("mw_br_deferred", 32'(ctrl()), 32'(MEMS));
        bus.PCSrcE = 1'b0; bus.ResultSrcE = 1'b0;
        tick();
        check("mw_c3", 32'(ctrl()), 32'(MEMS));
        tick();
        bus.mem_ready = 1'b1;
        settle();
        check("mw_done", 32'(ctrl()), 32'(IDLE));
        tick();
        bus.MemReqM = 1'b0; bus.mem_ready = 1'b0;
        settle();
        check("mw_back_run", 32'(ctrl()), 32'(IDLE));
        check("mw_no_timeout", 32'(bus.mem_timeout), 32'd0);

        bus.MemReqM = 1'b1; bus.mem_ready = 1'b1;
        settle();
        check("zero_wait", 32'(ctrl()), 32'(IDLE));
        tick();
        bus.mem_ready = 1'b0;
        settle();
        check("to_c1", 32'(ctrl()), 32'(MEMS));
        tick();
        tick();
        tick();
        check("to_c4", 32'(ctrl()), 32'(MEMS));
        check("to_not_yet", 32'(bus.mem_timeout), 32'd0);
        tick();
        check("to_flag", 32'(bus.mem_timeout), 32'd1);
        bus.mem_ready = 1'b1; bus.MemReqM = 1'b0;
        settle();
        check("halt_ignores_ready", 32'(ctrl()), 32'(MEMS));
        tick();
        check("halt_sticky", 32'(ctrl()), 32'(MEMS));
        clear_inputs();
        do_reset();
        check("rst_from_halt", 32'(ctrl()), 32'(IDLE));
        check("rst_clears_timeout", 32'(bus.mem_timeout), 32'd0);

        bus.ResultSrcE = 1'b1; bus.RdE = 5'd9; bus.Rs1D = 5'd9;
        tick();
        tick();
        clear_inputs();
        bus.PCSrcE = 1'b1;
        tick();
        clear_inputs();
        bus.MemReqM = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        clear_inputs();
        tick();
`ifdef PIPE_PERF_CNT_EN
        check("cnt_stall", bus.stall_cycles, 32'd5);
        check("cnt_flush", bus.flush_count, 32'd1);
`else
        check("cnt_stall_off", bus.stall_cycles, 32'd0);
        check("cnt_flush_off", bus.flush_count, 32'd0);
`endif
        check("cnt_end_idle", 32'(ctrl()), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
